// File: rtl/i2c_fifo_master_if.sv
// Host-side and I2C pad signals of i2c_fifo_master, bundled with master/slave views.
interface i2c_fifo_master_if;
    logic [7:0] fifo_in;
    logic       rdy;
    logic       start;
    logic       sda_in;
    logic       sda_out;
    logic       scl;
    logic       ended;
    logic       ack;

    modport master (
        input  fifo_in, rdy, start, sda_in,
        output sda_out, scl, ended, ack
    );

    modport slave (
        output fifo_in, rdy, start, sda_in,
        input  sda_out, scl, ended, ack
    );
endinterface

// File: rtl/i2c_fifo_master.sv
// Write-only I2C master draining a byte FIFO: START, bytes MSB-first with ACK slots, STOP.
// Optional macro I2C_NACK_ABORT_EN: a NACK ends the transfer with STOP and flushes the FIFO.
module i2c_fifo_master #(
    parameter int I2C_CLOCK_DIVIDER = 1000,
    parameter int FIFO_LENGTH       = 4
) (
    input  logic              clk,
    input  logic              rst,
    i2c_fifo_master_if.master bus
);
    localparam int Q  = I2C_CLOCK_DIVIDER / 4;
    localparam int QW = (Q > 1) ? $clog2(Q) : 1;
    localparam int PW = $clog2(FIFO_LENGTH);
    localparam int CW = $clog2(FIFO_LENGTH + 1);

    localparam logic [QW-1:0] Q_LAST = QW'(Q - 1);
    localparam logic [QW-1:0] Q_ONE  = QW'(1);
    localparam logic [PW-1:0] P_LAST = PW'(FIFO_LENGTH - 1);
    localparam logic [PW-1:0] P_ONE  = PW'(1);
    localparam logic [CW-1:0] C_FULL = CW'(FIFO_LENGTH);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

`ifdef I2C_NACK_ABORT_EN
    localparam logic ABORT_EN = 1'b1;
`else
    localparam logic ABORT_EN = 1'b0;
`endif

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_BIT   = 3'd2;
    localparam logic [2:0] ST_ACK   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    logic [2:0]    state_r,   state_nx_s;
    logic [1:0]    quarter_r, quarter_nx_s;
    logic [2:0]    bit_idx_r, bit_idx_nx_s;
    logic [QW-1:0] qcnt_r;
    logic [7:0]    shift_r;
    logic [7:0]    mem_r [FIFO_LENGTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          scl_r, sda_r, ended_r, ack_r;

    logic          tick_s, push_s, pop_s, flush_s, done_s, start_ok_s;
    logic          scl_s, sda_s;
    logic [7:0]    head_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == P_LAST) begin
            return '0;
        end else begin
            return p + P_ONE;
        end
    endfunction

    assign tick_s     = (qcnt_r == Q_LAST);
    assign push_s     = bus.rdy && (count_r != C_FULL);
    // A push in the same cycle as start is enough to make the FIFO non-empty.
    assign start_ok_s = bus.start && ((count_r != '0) || bus.rdy);
    assign head_s     = mem_r[rd_ptr_r];

    // Next-state, pop/flush and completion decisions at the end of each quarter.
    always_comb begin
        state_nx_s   = state_r;
        quarter_nx_s = quarter_r;
        bit_idx_nx_s = bit_idx_r;
        pop_s        = 1'b0;
        flush_s      = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                quarter_nx_s = 2'd0;
                if (start_ok_s) begin
                    state_nx_s = ST_START;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s && (quarter_r == 2'd1)) begin
                    state_nx_s   = ST_BIT;
                    quarter_nx_s = 2'd0;
                    bit_idx_nx_s = 3'd7;
                    pop_s        = 1'b1;
                end else if (tick_s) begin
                    quarter_nx_s = quarter_r + 2'd1;
                end else begin
                    quarter_nx_s = quarter_r;
                end
            end
            ST_BIT: begin
                if (tick_s && (quarter_r == 2'd3)) begin
                    quarter_nx_s = 2'd0;
                    if (bit_idx_r == 3'd0) begin
                        state_nx_s = ST_ACK;
                    end else begin
                        bit_idx_nx_s = bit_idx_r - 3'd1;
                    end
                end else if (tick_s) begin
                    quarter_nx_s = quarter_r + 2'd1;
                end else begin
                    quarter_nx_s = quarter_r;
                end
            end
            ST_ACK: begin
                if (tick_s && (quarter_r == 2'd3)) begin
                    quarter_nx_s = 2'd0;
                    if (ABORT_EN && !ack_r) begin
                        state_nx_s = ST_STOP;
                        flush_s    = 1'b1;
                    end else if (count_r != '0) begin
                        state_nx_s   = ST_BIT;
                        bit_idx_nx_s = 3'd7;
                        pop_s        = 1'b1;
                    end else begin
                        state_nx_s = ST_STOP;
                    end
                end else if (tick_s) begin
                    quarter_nx_s = quarter_r + 2'd1;
                end else begin
                    quarter_nx_s = quarter_r;
                end
            end
            ST_STOP: begin
                if (tick_s && (quarter_r == 2'd2)) begin
                    state_nx_s   = ST_IDLE;
                    quarter_nx_s = 2'd0;
                    done_s       = 1'b1;
                end else if (tick_s) begin
                    quarter_nx_s = quarter_r + 2'd1;
                end else begin
                    quarter_nx_s = quarter_r;
                end
            end
            default: begin
                state_nx_s   = ST_IDLE;
                quarter_nx_s = 2'd0;
            end
        endcase
    end

    // Line levels for the current state and quarter.
    always_comb begin
        scl_s = 1'b1;
        sda_s = 1'b1;
        case (state_r)
            ST_IDLE: begin
                scl_s = 1'b1;
                sda_s = 1'b1;
            end
            ST_START: begin
                scl_s = (quarter_r == 2'd0);
                sda_s = 1'b0;
            end
            ST_BIT: begin
                scl_s = quarter_r[1];
                sda_s = shift_r[bit_idx_r];
            end
            ST_ACK: begin
                scl_s = quarter_r[1];
                sda_s = 1'b1;
            end
            ST_STOP: begin
                scl_s = (quarter_r != 2'd0);
                sda_s = (quarter_r == 2'd2);
            end
            default: begin
                scl_s = 1'b1;
                sda_s = 1'b1;
            end
        endcase
    end

    // Sequencer state, quarter-tick counter and shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            quarter_r <= 2'd0;
            bit_idx_r <= 3'd7;
            qcnt_r    <= '0;
            shift_r   <= 8'h00;
        end else begin
            state_r   <= state_nx_s;
            quarter_r <= quarter_nx_s;
            bit_idx_r <= bit_idx_nx_s;
            if ((state_r == ST_IDLE) || tick_s) begin
                qcnt_r <= '0;
            end else begin
                qcnt_r <= qcnt_r + Q_ONE;
            end
            if (pop_s) begin
                shift_r <= head_s;
            end
        end
    end

    // FIFO storage; a byte offered while full is silently dropped.
    always_ff @(posedge clk) begin
        if (push_s && !flush_s) begin
            mem_r[wr_ptr_r] <= bus.fifo_in;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush_s) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + C_ONE;
                2'b01:   count_r <= count_r - C_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Registered pad drives, end pulse and ACK capture on the first clk of ACK q3.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_r   <= 1'b1;
            sda_r   <= 1'b1;
            ended_r <= 1'b0;
            ack_r   <= 1'b0;
        end else begin
            scl_r   <= scl_s;
            sda_r   <= sda_s;
            ended_r <= done_s;
            if ((state_r == ST_ACK) && (quarter_r == 2'd3) && (qcnt_r == '0)) begin
                ack_r <= ~bus.sda_in;
            end
        end
    end

    assign bus.scl     = scl_r;
    assign bus.sda_out = sda_r;
    assign bus.ended   = ended_r;
    assign bus.ack     = ack_r;
endmodule

// File: tb/tb_i2c_fifo_master.sv
// Self-checking bench for i2c_fifo_master: table vectors, random vectors and corner sequences.
module tb_i2c_fifo_master;
    localparam int DIV = 8;
    localparam int Q   = DIV / 4;
    localparam int FL  = 4;
`ifdef I2C_NACK_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    typedef struct packed {
        logic [5:0][7:0] data;
        int              n_push;
        logic [5:0]      nack;
        bit              with_rdy;
        int              exp_sent;
        logic            exp_ack;
        int              exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    i2c_fifo_master_if bus();

    i2c_fifo_master #(.I2C_CLOCK_DIVIDER(DIV), .FIFO_LENGTH(FL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Bus monitor and slave model.
    int         starts = 0;
    int         stops = 0;
    int         ended_cnt = 0;
    int         bitcnt = 0;
    int         byte_in_xfer = 0;
    logic [7:0] cur_byte = 8'h00;
    logic [7:0] wire_q [$];
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       slave_nack = 1'b0;
    logic       nack_pol [8];

    assign bus.sda_in = slave_nack;

    always @(negedge clk) begin
        if (!rst) begin
            prev_scl   = 1'b1;
            prev_sda   = 1'b1;
            bitcnt     = 0;
            slave_nack = 1'b0;
        end else begin
            if (prev_scl && bus.scl && prev_sda && !bus.sda_out) begin
                starts++;
                bitcnt       = 0;
                byte_in_xfer = 0;
            end else if (prev_scl && bus.scl && !prev_sda && bus.sda_out) begin
                stops++;
            end else if (!prev_scl && bus.scl) begin
                if (bitcnt < 8) begin
                    cur_byte = {cur_byte[6:0], bus.sda_out};
                    bitcnt++;
                    if (bitcnt == 8) begin
                        wire_q.push_back(cur_byte);
                        slave_nack = nack_pol[byte_in_xfer % 8];
                        byte_in_xfer++;
                    end
                end else begin
                    bitcnt = 0;
                end
            end
            if (bus.ended) ended_cnt++;
            prev_scl = bus.scl;
            prev_sda = bus.sda_out;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: FIFO keeps the first FL bytes; each byte goes out, a NACK may end it early.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   accepted;
        r          = v;
        accepted   = (v.n_push < FL) ? v.n_push : FL;
        r.exp_sent = 0;
        r.exp_ack  = 1'b0;
        for (int i = 0; i < accepted; i++) begin
            r.exp_sent++;
            r.exp_ack = !v.nack[i];
            if (ABORT && v.nack[i]) break;
        end
        r.exp_lat = (2 + 36 * r.exp_sent + 3) * Q;
        return r;
    endfunction

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        bus.rdy     = 1'b1;
        bus.fifo_in = b;
        @(negedge clk);
        bus.rdy     = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_ended(input string tag, output int n);
        bit got = 1'b0;
        n = 0;
        while (!got && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.ended) got = 1'b1;
        end
        if (!got) check({tag, " ended_timeout"}, n, -1);
    endtask

    task automatic idle_check(input string tag);
        int s0;
        s0 = starts;
        pulse_start();
        repeat (60) @(negedge clk);
        check({tag, " idle_no_start"}, starts, s0);
        check({tag, " idle_scl"}, int'(bus.scl), 1);
        check({tag, " idle_sda"}, int'(bus.sda_out), 1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int bq, bs, bp, be, n, sent;
        bq = wire_q.size();
        bs = starts;
        bp = stops;
        be = ended_cnt;
        for (int i = 0; i < 6; i++) nack_pol[i] = v.nack[i];
        for (int i = 0; i < v.n_push - (v.with_rdy ? 1 : 0); i++) push(v.data[i]);
        @(negedge clk);
        bus.start = 1'b1;
        if (v.with_rdy) begin
            bus.rdy     = 1'b1;
            bus.fifo_in = v.data[v.n_push - 1];
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.rdy   = 1'b0;
        wait_ended(tag, n);
        check({tag, " latency"}, n, v.exp_lat);
        check({tag, " ack"}, int'(bus.ack), int'(v.exp_ack));
        @(posedge clk);
        #1;
        check({tag, " ended_width"}, int'(bus.ended), 0);
        repeat (4) @(negedge clk);
        sent = wire_q.size() - bq;
        check({tag, " bytes_sent"}, sent, v.exp_sent);
        for (int i = 0; i < v.exp_sent && i < sent; i++)
            check($sformatf("%s byte%0d", tag, i), int'(wire_q[bq + i]), int'(v.data[i]));
        check({tag, " starts"}, starts - bs, 1);
        check({tag, " stops"}, stops - bp, 1);
        check({tag, " ended_pulses"}, ended_cnt - be, 1);
        idle_check(tag);
    endtask

    vec_t tbl [6];
    vec_t rv;

    initial begin
        int n, bq, bs, bp;
        bus.fifo_in = 8'h00;
        bus.rdy     = 1'b0;
        bus.start   = 1'b0;
        for (int i = 0; i < 8; i++) nack_pol[i] = 1'b0;

        tbl[0] = '0; tbl[0].n_push = 1; tbl[0].data[0] = 8'hA5;
        tbl[1] = '0; tbl[1].n_push = 4;
        tbl[1].data[0] = 8'h98; tbl[1].data[1] = 8'h12; tbl[1].data[2] = 8'h98; tbl[1].data[3] = 8'h34;
        tbl[2] = '0; tbl[2].n_push = 5;
        tbl[2].data[0] = 8'h11; tbl[2].data[1] = 8'h22; tbl[2].data[2] = 8'h33;
        tbl[2].data[3] = 8'h44; tbl[2].data[4] = 8'h55;
        tbl[3] = '0; tbl[3].n_push = 2; tbl[3].nack = 6'b000001;
        tbl[3].data[0] = 8'hC3; tbl[3].data[1] = 8'h3C;
        tbl[4] = '0; tbl[4].n_push = 1; tbl[4].with_rdy = 1'b1; tbl[4].data[0] = 8'h5A;
        tbl[5] = '0; tbl[5].n_push = 3; tbl[5].with_rdy = 1'b1;
        tbl[5].data[0] = 8'h01; tbl[5].data[1] = 8'h80; tbl[5].data[2] = 8'hFF;
        for (int i = 0; i < 6; i++) tbl[i] = model(tbl[i]);

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst scl", int'(bus.scl), 1);
        check("rst sda", int'(bus.sda_out), 1);
        check("rst ended", int'(bus.ended), 0);
        check("rst ack", int'(bus.ack), 0);
        @(negedge clk);
        rst = 1'b1;
        idle_check("empty_start");

        for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        for (int k = 0; k < 8; k++) begin
            rv        = '0;
            rv.n_push = $urandom_range(1, 6);
            rv.nack   = 6'($urandom);
            for (int i = 0; i < 6; i++) rv.data[i] = 8'($urandom);
            rv.with_rdy = (rv.n_push <= FL) ? 1'($urandom_range(0, 1)) : 1'b0;
            rv = model(rv);
            run_vec(rv, $sformatf("rnd%0d", k));
        end

        // Push during a transfer is appended.
        for (int i = 0; i < 8; i++) nack_pol[i] = 1'b0;
        bq = wire_q.size();
        push(8'h81);
        pulse_start();
        repeat (10) @(negedge clk);
        push(8'h7E);
        wait_ended("append", n);
        repeat (4) @(negedge clk);
        check("append bytes_sent", wire_q.size() - bq, 2);
        if (wire_q.size() - bq >= 2) begin
            check("append byte0", int'(wire_q[bq]), 8'h81);
            check("append byte1", int'(wire_q[bq + 1]), 8'h7E);
        end
        check("append ack", int'(bus.ack), 1);

        // Reset mid-byte releases the lines at once, emits no STOP and empties the FIFO.
        bs = starts;
        bp = stops;
        push(8'hF0);
        push(8'h0F);
        pulse_start();
        repeat (20) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst scl", int'(bus.scl), 1);
        check("midrst sda", int'(bus.sda_out), 1);
        check("midrst ended", int'(bus.ended), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle_check("midrst");
        check("midrst starts", starts - bs, 1);
        check("midrst no_stop", stops - bp, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
